multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. Sequences instruction fetch, register-file read and sign extension in decode, execution, memory access and register write-back. Drives every mux select and write strobe in the datapath, including RegDst for the write-register mux and RegWrite for the register file. Stalls on a single-ready memory handshake and flags unsupported opcodes.

---
 rtl/multicycle_control.sv | 162 ++++++++++++++++
 tb/tb_multicycle_control.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch, decode, execute,
// memory access and write-back sequencing with a single-ready memory stall.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RTYPEWB = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  state_t state_q, state_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state and datapath controls; everything held low while in reset
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          if (mem_ready) state_d = DECODE;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          case (opcode)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYPE:     state_d = EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_J:         state_d = JUMP;
            OP_ADDI:      state_d = ADDIEX;
            default: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
              state_d    = FETCH;
            end
          endcase
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) state_d = MEMWB;
        end
        MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) state_d = FETCH;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = RTYPEWB;
        end
        RTYPEWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
          state_d     = FETCH;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = ADDIWB;
        end
        ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and control-vector
// checks against hand-computed values for each instruction class.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite},
  // {RegWrite,RegDst,ALUSrcA}, ALUSrcB, ALUOp, PCSource, {instr_done,illegal_op}
  logic [17:0] outs;
  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                 instr_done, illegal_op};

  localparam logic [17:0] O_ZERO  = 18'd0;
  localparam logic [17:0] O_F1    = {7'b1001001, 3'b000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] O_F0    = {7'b0001000, 3'b000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] O_DEC   = {7'b0000000, 3'b000, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] O_DECIL = {7'b0000000, 3'b000, 2'b11, 2'b00, 2'b00, 2'b11};
  localparam logic [17:0] O_MADR  = {7'b0000000, 3'b001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] O_MRD   = {7'b0011000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] O_MWB   = {7'b0000010, 3'b100, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] O_MWR0  = {7'b0010100, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] O_MWR1  = {7'b0010100, 3'b000, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] O_EXEC  = {7'b0000000, 3'b001, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [17:0] O_RWB   = {7'b0000000, 3'b110, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] O_BR    = {7'b0100000, 3'b001, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [17:0] O_JMP   = {7'b1000000, 3'b000, 2'b00, 2'b00, 2'b10, 2'b10};
  localparam logic [17:0] O_AEX   = {7'b0000000, 3'b001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] O_AWB   = {7'b0000000, 3'b100, 2'b00, 2'b00, 2'b00, 2'b10};

  task automatic chk(input string tag, input logic [3:0] exp_st, input logic [17:0] exp_o);
    total++;
    assert (state === exp_st) else begin
      bad++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp_st);
    end
    total++;
    assert (outs === exp_o) else begin
      bad++;
      $error("FAIL %s outs observed=%b expected=%b", tag, outs, exp_o);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later
  task automatic step(input logic r, input logic mr, input logic [5:0] op,
                      input logic [3:0] exp_st, input logic [17:0] exp_o,
                      input string tag);
    @(negedge clk);
    rst       = r;
    mem_ready = mr;
    opcode    = op;
    #1;
    chk(tag, exp_st, exp_o);
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'h00;

    // reset held three cycles
    step(1, 1, 6'h00, 4'd0, O_ZERO, "rst0");
    step(1, 1, 6'h00, 4'd0, O_ZERO, "rst1");
    step(1, 1, 6'h00, 4'd0, O_ZERO, "rst2");

    // R-type
    step(0, 1, 6'h00, 4'd0, O_F1,   "r_fetch");
    step(0, 1, 6'h00, 4'd1, O_DEC,  "r_decode");
    step(0, 1, 6'h00, 4'd6, O_EXEC, "r_exec");
    step(0, 1, 6'h00, 4'd7, O_RWB,  "r_wb");

    // lw with FETCH and MEMRD stalls: 10 cycles
    step(0, 0, 6'h23, 4'd0, O_F0,   "lw_fetch_stall0");
    step(0, 0, 6'h23, 4'd0, O_F0,   "lw_fetch_stall1");
    step(0, 1, 6'h23, 4'd0, O_F1,   "lw_fetch");
    step(0, 1, 6'h23, 4'd1, O_DEC,  "lw_decode");
    step(0, 1, 6'h23, 4'd2, O_MADR, "lw_memadr");
    step(0, 0, 6'h23, 4'd3, O_MRD,  "lw_memrd_stall0");
    step(0, 0, 6'h23, 4'd3, O_MRD,  "lw_memrd_stall1");
    step(0, 0, 6'h23, 4'd3, O_MRD,  "lw_memrd_stall2");
    step(0, 1, 6'h23, 4'd3, O_MRD,  "lw_memrd");
    step(0, 1, 6'h23, 4'd4, O_MWB,  "lw_memwb");

    // sw
    step(0, 1, 6'h2B, 4'd0, O_F1,   "sw_fetch");
    step(0, 1, 6'h2B, 4'd1, O_DEC,  "sw_decode");
    step(0, 1, 6'h2B, 4'd2, O_MADR, "sw_memadr");
    step(0, 1, 6'h2B, 4'd5, O_MWR1, "sw_memwr");

    // beq
    step(0, 1, 6'h04, 4'd0, O_F1,   "beq_fetch");
    step(0, 1, 6'h04, 4'd1, O_DEC,  "beq_decode");
    step(0, 1, 6'h04, 4'd8, O_BR,   "beq_branch");

    // j
    step(0, 1, 6'h02, 4'd0, O_F1,   "j_fetch");
    step(0, 1, 6'h02, 4'd1, O_DEC,  "j_decode");
    step(0, 1, 6'h02, 4'd9, O_JMP,  "j_jump");

    // addi
    step(0, 1, 6'h08, 4'd0,  O_F1,  "addi_fetch");
    step(0, 1, 6'h08, 4'd1,  O_DEC, "addi_decode");
    step(0, 1, 6'h08, 4'd10, O_AEX, "addi_ex");
    step(0, 1, 6'h08, 4'd11, O_AWB, "addi_wb");

    // illegal opcode
    step(0, 1, 6'h3F, 4'd0, O_F1,    "ill_fetch");
    step(0, 1, 6'h3F, 4'd1, O_DECIL, "ill_decode");
    step(0, 1, 6'h2B, 4'd0, O_F1,    "ill_next_fetch");

    // sw stalled in MEMWR, then asynchronous reset mid-cycle
    step(0, 1, 6'h2B, 4'd1, O_DEC,  "sw2_decode");
    step(0, 1, 6'h2B, 4'd2, O_MADR, "sw2_memadr");
    step(0, 0, 6'h2B, 4'd5, O_MWR0, "sw2_memwr_stall");
    #2 rst = 1'b1;
    #1 chk("sw2_async_rst", 4'd0, O_ZERO);
    step(1, 1, 6'h00, 4'd0, O_ZERO, "sw2_rst_hold");

    // restart, then abort in RTYPEWB
    step(0, 1, 6'h00, 4'd0, O_F1,   "r2_fetch");
    step(0, 1, 6'h00, 4'd1, O_DEC,  "r2_decode");
    step(0, 1, 6'h00, 4'd6, O_EXEC, "r2_exec");
    step(0, 1, 6'h00, 4'd7, O_RWB,  "r2_wb");
    #2 rst = 1'b1;
    #1 chk("r2_async_rst", 4'd0, O_ZERO);
    step(1, 1, 6'h02, 4'd0, O_ZERO, "r2_rst_hold");
    step(0, 1, 6'h02, 4'd0, O_F1,   "post_fetch");
    step(0, 1, 6'h02, 4'd1, O_DEC,  "post_decode");
    step(0, 1, 6'h02, 4'd9, O_JMP,  "post_jump");
    step(0, 1, 6'h02, 4'd0, O_F1,   "post_fetch2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
